pwm_multi: RTL and testbench
============================

// Module: pwm_multi
// PURPOSE
//  NUM_CH-channel PWM generator with a shared, runtime-programmable period counter.
//  Supports edge-aligned and center-aligned modes.
//  Duty, period and mode are double-buffered: new values take effect only at a period
//  boundary, so outputs never glitch mid-period. Drives motor/LED PWM outputs.
// PARAMETERS
//  WIDTH   10  counter, period and per-channel duty width (bits)
//  NUM_CH  4   number of PWM output channels
// PORTS
//  clk         in   1             system clock, all logic on posedge
//  rst         in   1             asynchronous, active-high reset
//  en          in   1             1 = run; 0 = hold counter at 0, outputs low
//  period      in   WIDTH         requested period (edge: cycles; center: half-period)
//  duty        in   NUM_CH*WIDTH  requested duties; channel i = duty[i*WIDTH +: WIDTH]
//  center_mode in   1             requested mode: 0 = edge-aligned, 1 = center-aligned
//  update      in   1             1-cycle strobe: capture period/duty/center_mode into pending regs
//  PWM_sig     out  NUM_CH        registered PWM outputs
//  period_end  out  1             registered 1-cycle pulse, one per completed period
// BEHAVIOUR
//  Reset (async, rst=1):
//   - cnt=0, dir=up, active and pending regs=0, pend flag=0.
//   - PWM_sig=0 and period_end=0, effective immediately with no clock.
//  Registers: pending (per/duty/mode), written by update; active (per_a/duty_a/mode_a),
//   used by the datapath; pend flag set by update.
//  Boundary cycle = last counter value of a period:
//   - edge mode: cnt==per_a-1.
//   - center mode: dir=down and cnt==0.
//  At the boundary, if pend=1 (set before this cycle):
//   - active <= pending and pend <= 0.
//   - the counter restarts at cnt=0, dir=up.
//  Update on the boundary cycle itself: captured into pending, applied at the NEXT boundary.
//  Update while pend=1: overwrites pending (last update wins).
//  Edge mode:
//   - cnt counts 0..per_a-1, then wraps to 0.
//   - compare: hi_i = (cnt < duty_a[i]).
//  Center mode:
//   - cnt counts up 0..per_a-1, then down per_a-1..0; each endpoint is held 2 cycles.
//   - total period = 2*per_a cycles.
//   - compare: hi_i = (cnt >= per_a - duty_a[i]), giving 2*duty_a high cycles centered on the peak.
//  Saturation:
//   - duty_a==0: channel constant low.
//   - duty_a>=per_a: channel constant high.
//   - Compare with WIDTH+1-bit arithmetic; no wrap.
//  Latency: PWM_sig[i] <= hi_i, 1 clk after cnt; period_end <= boundary, 1 clk after boundary.
//  per_a==0: counter held 0, PWM_sig=0, no period_end; every cycle counts as a boundary,
//   so a pending update applies on the next clk.
//  en=0:
//   - cnt<=0, dir<=up; PWM_sig<=0 and period_end<=0 on the next clk.
//   - every cycle counts as a boundary (a pending update applies).
//  en 0->1: first period starts at cnt=0 with the current active regs.
//  Mode change via update: takes effect at a boundary only; the counter restarts at 0, dir=up.
// TESTING (WIDTH=10, NUM_CH=4)
//  1. Edge, per=10, duty={12,10,0,3} (ch3..ch0):
//     -> ch0 high 3/10 cycles; ch1 always low; ch2 and ch3 always high;
//        period_end every 10 clks.
//  2. Center, per=8, duty ch0=2:
//     -> period 16 clks; ch0 high 4 clks while cnt in {6,7,7,6};
//        period_end once per 16 clks.
//  3. Edge, per=10, duty0=3; update duty0=7 at cnt=5
//     -> current period stays 3 high; next period 7 high; no extra edges.
//  4. Update (duty0 3->5) on the boundary cycle -> next period 3; the one after 5.
//  5. en=0 at cnt=4 with ch0 high
//     -> PWM_sig=0 next clk, cnt=0; en=1 -> fresh period from cnt=0 (pending applied).
//  6. Assert rst mid-period, between clk edges
//     -> PWM_sig=0 and period_end=0 with no clock; after release,
//        outputs stay 0 until new config is loaded via update.

Source files
------------

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared programmable period counter.
// Edge- or center-aligned; period/duty/mode are double-buffered and switch only at period ends.
module pwm_multi #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WIDTH-1:0]        period,
  input  logic [NUM_CH*WIDTH-1:0] duty,
  input  logic                    center_mode,
  input  logic                    update,
  output logic [NUM_CH-1:0]       PWM_sig,
  output logic                    period_end
);

  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic                    dir_q, dir_d;
  logic [WIDTH-1:0]        per_p_q, per_a_q, per_a_d;
  logic [NUM_CH*WIDTH-1:0] duty_p_q, duty_a_q, duty_a_d;
  logic                    mode_p_q, mode_a_q, mode_a_d;
  logic                    pend_q, pend_d;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic                    pe_q, pe_d;

  logic             run;
  logic             edge_bnd;
  logic             ctr_bnd;
  logic             bnd;
  logic [WIDTH-1:0] per_m1;
  logic [WIDTH-1:0] duty_i;

  always_comb begin
    per_m1   = per_a_q - One;
    run      = en && (per_a_q != '0);
    edge_bnd = !mode_a_q && (cnt_q == per_m1);
    ctr_bnd  = mode_a_q && (dir_q == DirDown) && (cnt_q == '0);
    // Idle cycles (disabled or zero period) count as boundaries so pending config can load.
    bnd      = !run || edge_bnd || ctr_bnd;

    cnt_d    = cnt_q;
    dir_d    = dir_q;
    per_a_d  = per_a_q;
    duty_a_d = duty_a_q;
    mode_a_d = mode_a_q;
    pend_d   = pend_q;

    if (!run) begin
      cnt_d = '0;
      dir_d = DirUp;
    end else if (mode_a_q) begin
      // Endpoints hold for two cycles: only the direction flips there.
      if (dir_q == DirUp) begin
        if (cnt_q == per_m1) dir_d = DirDown;
        else                 cnt_d = cnt_q + One;
      end else begin
        if (cnt_q == '0) dir_d = DirUp;
        else             cnt_d = cnt_q - One;
      end
    end else begin
      cnt_d = edge_bnd ? '0 : cnt_q + One;
    end

    if (bnd && pend_q) begin
      per_a_d  = per_p_q;
      duty_a_d = duty_p_q;
      mode_a_d = mode_p_q;
      pend_d   = 1'b0;
      cnt_d    = '0;
      dir_d    = DirUp;
    end
    if (update) pend_d = 1'b1;

    pwm_d  = '0;
    duty_i = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      duty_i = duty_a_q[i*WIDTH +: WIDTH];
      // WIDTH+1-bit compares so saturated duties never wrap.
      if (mode_a_q) pwm_d[i] = run && (({1'b0, cnt_q} + {1'b0, duty_i}) >= {1'b0, per_a_q});
      else          pwm_d[i] = run && ({1'b0, cnt_q} < {1'b0, duty_i});
    end
    pe_d = run && (edge_bnd || ctr_bnd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      dir_q    <= DirUp;
      per_p_q  <= '0;
      duty_p_q <= '0;
      mode_p_q <= 1'b0;
      per_a_q  <= '0;
      duty_a_q <= '0;
      mode_a_q <= 1'b0;
      pend_q   <= 1'b0;
      pwm_q    <= '0;
      pe_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      per_a_q  <= per_a_d;
      duty_a_q <= duty_a_d;
      mode_a_q <= mode_a_d;
      pend_q   <= pend_d;
      pwm_q    <= pwm_d;
      pe_q     <= pe_d;
      if (update) begin
        per_p_q  <= period;
        duty_p_q <= duty;
        mode_p_q <= center_mode;
      end
    end
  end

  assign PWM_sig    = pwm_q;
  assign period_end = pe_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a period-position model predicts every output cycle.
module tb_pwm_multi;
  localparam int W = 10;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [W-1:0]     period;
  logic [N*W-1:0]   duty;
  logic             center_mode;
  logic             update;
  logic [N-1:0]     PWM_sig;
  logic             period_end;

  pwm_multi #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty),
    .center_mode(center_mode), .update(update), .PWM_sig(PWM_sig), .period_end(period_end)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [N-1:0] pwm; logic pe;} exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Model: k is the position inside the current period (0 .. length-1).
  int k;
  int per_a, mode_a, per_p, mode_p, pend;
  int duty_a[N];
  int duty_p[N];

  task automatic model_reset();
    k = 0; per_a = 0; mode_a = 0; per_p = 0; mode_p = 0; pend = 0;
    for (int i = 0; i < N; i++) begin duty_a[i] = 0; duty_p[i] = 0; end
  endtask

  task automatic model_step();
    exp_t e;
    bit   bnd;
    int   len, c;
    e = '0;
    if (rst) begin
      model_reset();
    end else begin
      if (!en || per_a == 0) begin
        k = 0;
        bnd = 1;
      end else begin
        len = mode_a ? 2 * per_a : per_a;
        c = (mode_a && k >= per_a) ? 2 * per_a - 1 - k : k;
        for (int i = 0; i < N; i++)
          e.pwm[i] = mode_a ? (c + duty_a[i] >= per_a) : (c < duty_a[i]);
        bnd = (k == len - 1);
        e.pe = bnd;
        k = (k + 1) % len;
      end
      if (bnd && pend != 0) begin
        per_a = per_p; mode_a = mode_p;
        for (int i = 0; i < N; i++) duty_a[i] = duty_p[i];
        pend = 0;
        k = 0;
      end
      if (update) begin
        per_p = int'(period); mode_p = int'(center_mode);
        for (int i = 0; i < N; i++) duty_p[i] = int'(duty[i*W +: W]);
        pend = 1;
      end
    end
    q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: one output word per cycle, sampled mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (PWM_sig !== e.pwm || period_end !== e.pe) begin
          n_err++;
          $display("FAIL cycle_out t=%0t: got pwm=%b pe=%b, expected pwm=%b pe=%b",
                   $time, PWM_sig, period_end, e.pwm, e.pe);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_update(input int p, input int d0, input int d1, input int d2, input int d3,
                           input int m);
    period      = W'(p);
    duty        = {W'(d3), W'(d2), W'(d1), W'(d0)};
    center_mode = m[0];
    update      = 1'b1;
    @(negedge clk);
    update      = 1'b0;
  endtask

  // Wait until the current cycle's counter position equals target, bounded.
  task automatic wait_k(input int target, input string name);
    int budget;
    budget = 200;
    while (k != target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (k != target) begin
      n_err++;
      $display("FAIL %s: position %0d never reached (at %0d)", name, target, k);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1; en = 1'b0; period = '0; duty = '0; center_mode = 1'b0; update = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(4);

    // Edge, per=10, duty ch0..ch3 = 3,0,10,12
    do_update(10, 3, 0, 10, 12, 0);
    cyc(35);

    // Async reset between edges while ch2/ch3 are high
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (PWM_sig !== '0 || period_end !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got pwm=%b pe=%b, expected pwm=0000 pe=0", PWM_sig,
               period_end);
    end
    cyc(3);
    rst = 1'b0;
    cyc(15);

    // Center, per=8, ch0 duty 2
    do_update(8, 2, 0, 8, 5, 1);
    cyc(40);

    // Mid-period duty change applies next period
    do_update(10, 3, 1, 9, 4, 0);
    cyc(20);
    wait_k(5, "mid_update");
    do_update(10, 7, 1, 9, 4, 0);
    cyc(25);

    // Update on the boundary cycle is deferred one period
    do_update(10, 3, 1, 9, 4, 0);
    cyc(20);
    wait_k(9, "bnd_update");
    do_update(10, 5, 1, 9, 4, 0);
    cyc(30);

    // en drop at cnt=4 with a pending update
    wait_k(2, "pend_before_en");
    do_update(10, 6, 2, 8, 4, 0);
    wait_k(4, "en_drop");
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(25);

    // Randomised configs, mode switches and enable toggles
    for (int it = 0; it < 2500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        do_update(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 16),
                  $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                  ($urandom_range(0, 4) == 0) ? 1023 : $urandom_range(0, 20),
                  $urandom_range(0, 1));
      end else if (r < 8) begin
        en = ~en;
        cyc(1);
      end else begin
        cyc(1);
      end
    end
    en = 1'b1;
    cyc(5);

    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs never compared, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
